// File: rtl/snowbro2_pkg.sv
// Shared definitions for the Snow Bros 2 sound-bus CEN bridges:
// state encoding, per-peripheral hold defaults and the strobe counter helper.
package snowbro2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SYNC   = ST_SYNC,
        ACTIVE = ST_ACTIVE,
        DONE   = ST_DONE
    } bridge_state_t;

    localparam int HOLD_YM2151 = 2;
    localparam int HOLD_OKI    = 1;

    localparam int         CNT_W   = 4;
    localparam logic [3:0] CNT_MAX = 4'hF;

    // Saturating strobe counter step; it must never wrap back to a small value.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 4'd1;
    endfunction

endpackage

// File: rtl/snowbro2_cen_bridge.sv
// Carries a CPU bus cycle from the 96 MHz fabric into a CEN-strobed peripheral
// and answers the master with a 4-phase REQ/ACK handshake.
module snowbro2_cen_bridge
    import snowbro2_pkg::*;
#(
    parameter int AW   = 1,
    parameter int DW   = 8,
    parameter int HOLD = HOLD_YM2151
) (
    input  logic          CLK96,
    input  logic          RESETn,
    input  logic          CEN,
    input  logic          REQ,
    input  logic          WE,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DIN,
    output logic          ACK,
    output logic [DW-1:0] DOUT,
    output logic          BUSY,
    output logic          P_CS,
    output logic          P_WE,
    output logic [AW-1:0] P_ADDR,
    output logic [DW-1:0] P_DOUT,
    input  logic [DW-1:0] P_DIN
);

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD);

    bridge_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ack_nxt, busy_nxt, cs_nxt, we_nxt;
    logic [DW-1:0]    dout_nxt, wdata_nxt;
    logic [AW-1:0]    addr_nxt;

    // All outputs are flops; the comb process only decides their next values.
    always_ff @(posedge CLK96 or negedge RESETn) begin
        if (!RESETn) begin
            state  <= IDLE;
            cnt    <= '0;
            ACK    <= 1'b0;
            DOUT   <= '0;
            BUSY   <= 1'b0;
            P_CS   <= 1'b0;
            P_WE   <= 1'b0;
            P_ADDR <= '0;
            P_DOUT <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ACK    <= ack_nxt;
            DOUT   <= dout_nxt;
            BUSY   <= busy_nxt;
            P_CS   <= cs_nxt;
            P_WE   <= we_nxt;
            P_ADDR <= addr_nxt;
            P_DOUT <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = ACK;
        dout_nxt  = DOUT;
        cs_nxt    = P_CS;
        we_nxt    = P_WE;
        addr_nxt  = P_ADDR;
        wdata_nxt = P_DOUT;

        case (state)
            // CEN is ignored here so a strobe coincident with REQ is never counted.
            IDLE: begin
                if (REQ) begin
                    we_nxt    = WE;
                    addr_nxt  = ADDR;
                    wdata_nxt = DIN;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (CEN) begin
                    cs_nxt    = 1'b1;
                    cnt_nxt   = 4'd1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (CEN) begin
                    cnt_nxt = cnt_inc(cnt);
                    if (cnt == HOLD_CNT) begin
                        cs_nxt    = 1'b0;
                        ack_nxt   = 1'b1;
                        state_nxt = DONE;
                        if (!P_WE) begin
                            dout_nxt = P_DIN;
                        end
                    end
                end
            end
            DONE: begin
                if (!REQ) begin
                    ack_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_snowbro2_cen_bridge.sv
// Bench for snowbro2_cen_bridge: a YM2151-style (HOLD=2) and an OKI-style (HOLD=1)
// bridge, each checked every cycle against a transaction-level timing model.
module tb_snowbro2_cen_bridge;

    localparam int AW    = 1;
    localparam int DW    = 8;
    localparam int HOLD0 = 2;
    localparam int HOLD1 = 1;

    logic clk;
    logic rst_n;

    logic [1:0]         cen, req, we, ack, busy, pcs, pwe;
    logic [1:0][AW-1:0] addr, paddr;
    logic [1:0][DW-1:0] din, dout, pdout, pdin;

    int checks  = 0;
    int errors  = 0;
    int edgeNum = 0;
    int per[2];
    int ph[2];
    logic [DW-1:0] doutModel [2];

    snowbro2_cen_bridge #(.AW(AW), .DW(DW), .HOLD(HOLD0)) u_ym (
        .CLK96(clk), .RESETn(rst_n), .CEN(cen[0]), .REQ(req[0]), .WE(we[0]),
        .ADDR(addr[0]), .DIN(din[0]), .ACK(ack[0]), .DOUT(dout[0]), .BUSY(busy[0]),
        .P_CS(pcs[0]), .P_WE(pwe[0]), .P_ADDR(paddr[0]), .P_DOUT(pdout[0]), .P_DIN(pdin[0])
    );

    snowbro2_cen_bridge #(.AW(AW), .DW(DW), .HOLD(HOLD1)) u_oki (
        .CLK96(clk), .RESETn(rst_n), .CEN(cen[1]), .REQ(req[1]), .WE(we[1]),
        .ADDR(addr[1]), .DIN(din[1]), .ACK(ack[1]), .DOUT(dout[1]), .BUSY(busy[1]),
        .P_CS(pcs[1]), .P_WE(pwe[1]), .P_ADDR(paddr[1]), .P_DOUT(pdout[1]), .P_DIN(pdin[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeNum = edgeNum + 1;

    function automatic int holdOf(input int k);
        return (k == 0) ? HOLD0 : HOLD1;
    endfunction

    // CEN schedule as a pure function of the edge number.
    function automatic bit cenAt(input int k, input int e);
        if (per[k] <= 1) return 1'b1;
        return (e % per[k]) == ph[k];
    endfunction

    function automatic int nextCen(input int k, input int e);
        for (int x = e + 1; x <= e + 100; x++) begin
            if (cenAt(k, x)) return x;
        end
        return e + 100;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) cen[k] = cenAt(k, edgeNum + 1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setPeriod(input int k, input int p, input int phase);
        per[k] = p;
        ph[k]  = phase;
        repeat (2) @(negedge clk);
    endtask

    // One master transfer; expected timing comes from counting CEN edges only.
    task automatic applyStimulus(input int k, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [DW-1:0] rd,
                                 input bit early, input bit align);
        int lat, first, last, guard;
        logic expCs, expAck, expBusy, expWe;
        @(negedge clk);
        guard = 0;
        while (align && !cenAt(k, edgeNum + 1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        lat   = edgeNum + 1;
        first = nextCen(k, lat);
        last  = first;
        for (int i = 0; i < holdOf(k); i++) last = nextCen(k, last);
        req[k]  = 1'b1;
        we[k]   = w;
        addr[k] = a;
        din[k]  = d;
        pdin[k] = rd ^ DW'($urandom_range(1, 255));
        for (int e = lat; e <= last + 1; e++) begin
            @(posedge clk);
            #1;
            expCs   = (e >= first) && (e < last);
            expAck  = (e == last);
            expBusy = (e <= last);
            expWe   = (e <= last) ? w : 1'b0;
            if (e == last && !w) doutModel[k] = rd;
            checkOutput($sformatf("k%0d c%0d P_CS", k, e - lat), 32'(pcs[k]), 32'(expCs));
            checkOutput($sformatf("k%0d c%0d ACK", k, e - lat), 32'(ack[k]), 32'(expAck));
            checkOutput($sformatf("k%0d c%0d BUSY", k, e - lat), 32'(busy[k]), 32'(expBusy));
            checkOutput($sformatf("k%0d c%0d P_WE", k, e - lat), 32'(pwe[k]), 32'(expWe));
            checkOutput($sformatf("k%0d c%0d P_ADDR", k, e - lat), 32'(paddr[k]), 32'(a));
            checkOutput($sformatf("k%0d c%0d P_DOUT", k, e - lat), 32'(pdout[k]), 32'(d));
            checkOutput($sformatf("k%0d c%0d DOUT", k, e - lat), 32'(dout[k]), 32'(doutModel[k]));
            if (e <= last) begin
                @(negedge clk);
                pdin[k] = (e + 1 == last) ? rd : (rd ^ DW'($urandom_range(1, 255)));
                if ((early && e == lat) || e == last) begin
                    req[k]  = 1'b0;
                    we[k]   = 1'($urandom);
                    addr[k] = AW'($urandom);
                    din[k]  = DW'($urandom);
                end
            end
        end
    endtask

    task automatic resetMidActive(input int k);
        int lat, first;
        @(negedge clk);
        lat     = edgeNum + 1;
        first   = nextCen(k, lat);
        req[k]  = 1'b1;
        we[k]   = 1'b1;
        addr[k] = 1'b1;
        din[k]  = 8'h77;
        for (int e = lat; e <= first + 1; e++) @(posedge clk);
        #1;
        checkOutput("rst pre P_CS", 32'(pcs[k]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst async P_CS", 32'(pcs[k]), 32'd0);
        checkOutput("rst async ACK", 32'(ack[k]), 32'd0);
        checkOutput("rst async BUSY", 32'(busy[k]), 32'd0);
        checkOutput("rst async P_WE", 32'(pwe[k]), 32'd0);
        checkOutput("rst async P_ADDR", 32'(paddr[k]), 32'd0);
        doutModel[0] = '0;
        doutModel[1] = '0;
        @(negedge clk);
        req[k] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    int k, p, sel;

    initial begin
        rst_n = 1'b0;
        cen = '0; req = '0; we = '0; addr = '0; din = '0; pdin = '0;
        doutModel[0] = '0;
        doutModel[1] = '0;
        per[0] = 28; ph[0] = 0;
        per[1] = 1;  ph[1] = 0;
        #12;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset k%0d ACK", i), 32'(ack[i]), 32'd0);
            checkOutput($sformatf("reset k%0d BUSY", i), 32'(busy[i]), 32'd0);
            checkOutput($sformatf("reset k%0d P_CS", i), 32'(pcs[i]), 32'd0);
            checkOutput($sformatf("reset k%0d P_WE", i), 32'(pwe[i]), 32'd0);
            checkOutput($sformatf("reset k%0d DOUT", i), 32'(dout[i]), 32'd0);
            checkOutput($sformatf("reset k%0d P_DOUT", i), 32'(pdout[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] directed: CEN/28 write, read, coincident CEN");
        applyStimulus(0, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 8'h11, 8'h3C, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 8'h22, 8'hC3, 1'b0, 1'b1);

        $display("[TB] directed: CEN high, HOLD=1 back-to-back reads");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b0, AW'(i), DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        end

        $display("[TB] directed: reset in ACTIVE, then normal transfer");
        setPeriod(0, 4, 1);
        resetMidActive(0);
        applyStimulus(0, 1'b0, 1'b1, 8'h5A, 8'h96, 1'b0, 1'b0);

        $display("[TB] directed: REQ withdrawn in SYNC");
        setPeriod(0, 6, 3);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h4B, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 8'hE7, 8'h00, 1'b1, 1'b0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 30; n++) begin
            k   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       p = 1;
                1:       p = 2;
                2:       p = 3;
                3:       p = 5;
                default: p = 7;
            endcase
            setPeriod(k, p, int'($urandom_range(0, p - 1)));
            applyStimulus(k, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                          ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
